// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding / hazard unit.
//   STG_*   : stage indices of the tracked pipeline (0 = EXE, 1 = MEM, 2 = WB)
//   FWD_RF  : select encoding meaning "take operand from the register file"
//   REG_PC  : architectural PC register, never forwarded
//   TAG_AW  : widest register address a tag can carry
//   tag_t   : per-stage destination tag {valid, load, destination}
package fwd_pkg;

   localparam int STG_EXE = 0;
   localparam int STG_MEM = 1;
   localparam int STG_WB  = 2;

   localparam int FWD_RF  = 0;
   localparam int REG_PC  = 15;

   // Tags store the destination zero-extended to this width so a single
   // struct type serves any register address width up to TAG_AW.
   localparam int TAG_AW  = 8;

   typedef struct packed {
      logic              v;
      logic              ld;
      logic [TAG_AW-1:0] dst;
   } tag_t;

endpackage

// File: rtl/fwd_match.sv
// Priority match of one source operand against all tracked stage tags.
// Ports:
//   tags   in   NSTG tags, index 0 = youngest (EXE)
//   src    in   source register address
//   used   in   operand address is meaningful
//   sel    out  0 = register file, i+1 = result of stage i (youngest match)
//   hazard out  youngest match is a load whose data is not yet forwardable
module fwd_match
   import fwd_pkg::*;
#(
   parameter int AW         = 4,
   parameter int NSTG       = 3,
   parameter int LOAD_AVAIL = 1,
   parameter int NOFWD_REG  = REG_PC,
   parameter int SW         = $clog2(NSTG+1)
) (
   input  tag_t [NSTG-1:0] tags,
   input  logic [AW-1:0]   src,
   input  logic            used,
   output logic [SW-1:0]   sel,
   output logic            hazard
);

   logic [TAG_AW-1:0] src_ext;
   logic              fwd_ok;

   assign src_ext = TAG_AW'(src);
   assign fwd_ok  = used && (src != AW'(NOFWD_REG));

   // Walk from oldest to youngest so the youngest match is written last
   // and wins; the hazard bit is taken from that same match only.
   always_comb begin
      sel    = SW'(FWD_RF);
      hazard = 1'b0;
      for (int i = NSTG-1; i >= 0; i--) begin
         if (fwd_ok && tags[i].v && (tags[i].dst == src_ext)) begin
            sel    = SW'(i + 1);
            hazard = tags[i].ld && (i < LOAD_AVAIL);
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the pipelined core.
// Tracks destination tags for EXE..WB, produces per-operand forwarding
// selects for the instruction in decode, a load-use stall and a
// saturating stall-cycle counter.
// Ports:
//   clk, rst_n   clock (rising edge), synchronous active-low reset
//   iss_valid    decode holds a valid instruction requesting issue
//   iss_wen      instruction writes a register
//   iss_dst      destination register
//   iss_load     instruction is a load
//   src_addr     packed source addresses, operand k at [k*AW +: AW]
//   src_used     per-operand address-meaningful mask
//   flush        kill decode and EXE
//   fwd_sel      packed selects, operand k at [k*SW +: SW]
//   stall        hold decode/fetch this cycle
//   stall_cnt    saturating count of stall cycles
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int NSRC       = 3,
   parameter int AW         = 4,
   parameter int NSTG       = 3,
   parameter int LOAD_AVAIL = 1,
   parameter int NOFWD_REG  = REG_PC,
   parameter int CW         = 16,
   parameter int SW         = $clog2(NSTG+1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               iss_valid,
   input  logic               iss_wen,
   input  logic [AW-1:0]      iss_dst,
   input  logic               iss_load,
   input  logic [NSRC*AW-1:0] src_addr,
   input  logic [NSRC-1:0]    src_used,
   input  logic               flush,
   output logic [NSRC*SW-1:0] fwd_sel,
   output logic               stall,
   output logic [CW-1:0]      stall_cnt
);

   if (LOAD_AVAIL >= NSTG || NSTG < 1 || NSRC < 1) begin : g_bad_cfg
      $error("fwd_hazard_unit: need NSTG >= 1, NSRC >= 1, LOAD_AVAIL < NSTG");
   end
   if (AW > TAG_AW || SW < $clog2(NSTG+1)) begin : g_bad_width
      $error("fwd_hazard_unit: AW exceeds tag width or SW too narrow");
   end

   tag_t [NSTG-1:0] tag_q;
   logic [NSRC-1:0] haz;
   logic [CW-1:0]   cnt_q;
   logic            accept;

   for (genvar k = 0; k < NSRC; k++) begin : g_src
      fwd_match #(
         .AW         (AW),
         .NSTG       (NSTG),
         .LOAD_AVAIL (LOAD_AVAIL),
         .NOFWD_REG  (NOFWD_REG),
         .SW         (SW)
      ) u_match (
         .tags   (tag_q),
         .src    (src_addr[k*AW +: AW]),
         .used   (src_used[k]),
         .sel    (fwd_sel[k*SW +: SW]),
         .hazard (haz[k])
      );
   end

   // flush overrides stall: the decode instruction is being killed anyway.
   assign stall     = iss_valid & ~flush & (|haz);
   assign accept    = iss_valid & ~stall & ~flush;
   assign stall_cnt = cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_q <= '0;
         cnt_q <= '0;
      end else begin
         for (int i = NSTG-1; i > STG_EXE; i--) begin
            tag_q[i] <= tag_q[i-1];
            // The EXE instruction moving into MEM is killed along with decode.
            if (i == STG_MEM && flush) begin
               tag_q[i].v <= 1'b0;
            end
         end
         if (accept) begin
            tag_q[STG_EXE] <= '{v: iss_wen, ld: iss_load, dst: TAG_AW'(iss_dst)};
         end else begin
            tag_q[STG_EXE] <= '0;
         end
         if (stall && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the pipelined ARM core.
- Owns the destination-tag pipeline for stages EXE..WB internally: captures each issued instruction's destination, load flag and valid bit, then shifts them every cycle.
- For NSRC source operands of the instruction in decode, produces per-operand forwarding selects and a load-use stall.
- Adds flush, a no-forward register (PC) and a saturating stall counter.

Parameters:
- NSRC, 3, number of source operands checked per issue.
- AW, 4, register address width.
- NSTG, 3, tracked stages after decode (index 0 = EXE, 1 = MEM, 2 = WB).
- LOAD_AVAIL, 1, first stage index at which load data can be forwarded.
- NOFWD_REG, 15, register address never forwarded (PC).
- CW, 16, stall counter width.
- SW, $clog2(NSTG+1), width of one forwarding select.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- iss_valid  in  1  decode holds a valid instruction requesting issue.
- iss_wen  in  1  instruction writes a register.
- iss_dst  in  AW  destination register.
- iss_load  in  1  instruction is a load (data late).
- src_addr  in  NSRC*AW  packed source addresses, operand k at [k*AW +: AW].
- src_used  in  NSRC  per-operand "address is meaningful" mask.
- flush  in  1  branch/exception kill of decode and EXE.
- fwd_sel  out  NSRC*SW  packed selects: 0 = register file, s = stage s-1 result.
- stall  out  1  hold decode/fetch this cycle.
- stall_cnt  out  CW  saturating count of stall cycles.

Behaviour:
- Internal state: per stage i, {v[i], dst[i], ld[i]}; v set only if the instruction had iss_wen = 1.
- Reset (rst_n = 0 at a clock edge): all v = 0, stall_cnt = 0. Consequently fwd_sel = 0 and stall = 0 from the first cycle after reset.
- Reset mid-operation discards all in-flight tags; no stall persists.
- Match: operand k matches stage i when src_used[k] = 1, v[i] = 1, dst[i] == src_addr[k], and src_addr[k] != NOFWD_REG.
- fwd_sel[k]: combinational, equals i+1 for the lowest (youngest) matching i; 0 if no match.
- Stall: combinational, stall = iss_valid & ~flush & (any k matches some i < LOAD_AVAIL with ld[i] = 1).
- Stall is evaluated on the youngest match only. An older non-load match never masks a younger load match.
- While stall = 1, fwd_sel is still driven but is don't-care.
- Shift each rising edge (rst_n = 1): stage i+1 <= stage i for i = 0..NSTG-2, unconditionally. The WB entry drops off.
- Stage 0 load:
  - accept = iss_valid & ~stall & ~flush.
  - On accept: v[0] <= iss_wen, dst[0] <= iss_dst, ld[0] <= iss_load.
  - Otherwise a bubble is inserted: v[0] <= 0.
- Flush: the stage 0 entry being shifted into stage 1 is also killed (v[1] <= 0). Later stages are unaffected. flush has priority over stall.
- Latency: an instruction accepted at edge N is matched as stage 0 during cycle N+1, stage 1 during N+2, and so on.
- stall_cnt increments at each edge where stall = 1. It holds at 2^CW-1.
- Writes to NOFWD_REG are still tracked, but never matched.
- Elaboration check: LOAD_AVAIL < NSTG, NSTG >= 1, NSRC >= 1.

Decomposition:
- Shared package fwd_pkg holds:
  - stage index constants STG_EXE = 0, STG_MEM = 1, STG_WB = 2;
  - FWD_RF = 0 select encoding;
  - REG_PC = 15;
  - typedef tag_t {v, ld, dst}.
- One sub-module, fwd_match, instantiated once per operand: priority match of one source against all NSTG tags, producing sel and its load-hazard bit.
- Tag pipeline, stall logic and counter live in the top module.

Test Plan (defaults throughout):
- Reset and basic forwarding: reset for 2 cycles, then release. Accept iss_dst = 3, iss_wen = 1, iss_load = 0. Present src0 = 3 (used) on each following cycle -> fwd_sel0 = 1, 2, 3, then 0. stall = 0 throughout.
- Load-use: accept a load to r5, then present src1 = 5 -> stall = 1 for exactly one cycle and stall_cnt = 1. Next cycle stall = 0 with fwd_sel1 = 2; the instruction is accepted and stage 0 holds the bubble.
- Youngest priority: r2 written two cycles in a row. Next cycle src0 = src2 = 2 -> fwd_sel0 = fwd_sel2 = 1, not 2.
- PC and unused operands:
  - src0 = 15 with r15 in EXE -> fwd_sel0 = 0.
  - src1 = 3 with src_used[1] = 0 and r3 in EXE -> fwd_sel1 = 0.
- Flush:
  - Load r4 accepted, then flush = 1 while src0 = 4 -> stall = 0, no accept.
  - Next cycle src0 = 4 -> fwd_sel0 = 0, since the load was killed.
- Counter and reset mid-op:
  - Force the counter to 0xFFFF (CW = 16) and stall once more -> it remains at 0xFFFF.
  - Assert rst_n = 0 with a load in EXE -> next cycle stall = 0, stall_cnt = 0, all fwd_sel = 0.
